// File: rtl/ogpu_quad_pkg.sv
// ogpu_quad_pkg: shared widths, store record and capture FSM encoding
package ogpu_quad_pkg;
    localparam int OGPU_STORE_AW = 32;
    localparam int OGPU_STORE_DW = 64;
    typedef struct packed {
        logic [OGPU_STORE_AW-1:0] addr;
        logic [OGPU_STORE_DW-1:0] data;
    } ogpu_store_rec_t;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } ogpu_store_state_t;
endpackage

// File: rtl/ogpu_sync_fifo.sv
// ogpu_sync_fifo: single-clock show-ahead FIFO with occupancy count
module ogpu_sync_fifo #(
    parameter int W = 96,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    assign dout = mem[rd_ptr];
    // storage write; contents need no reset because count gates every read
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    // pointers wrap modulo DEPTH; full/empty come from count alone
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
        end
endmodule

// File: rtl/ogpu_quad_store_capture.sv
// ogpu_quad_store_capture: queues store records and presents them to host PIOs under a 4-phase ack
module ogpu_quad_store_capture
    import ogpu_quad_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = OGPU_STORE_AW,
    parameter int DW = OGPU_STORE_DW,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic [AW-1:0] store_addr,
    output logic [31:0]   store_data_high,
    output logic [31:0]   store_data_low,
    output logic          store_pending,
    input  logic          host_ack,
    output logic [CW-1:0] fifo_count
);
    ogpu_store_state_t state;
    ogpu_store_state_t next_state;
    logic [AW+DW-1:0]  head;
    logic              push;
    logic              pop;
    logic              load;
    assign st_ready = fifo_count != CW'(DEPTH);
    assign push = st_valid && st_ready;
    assign load = state == ST_IDLE && fifo_count != '0 && !host_ack;
    assign pop  = state == ST_PRESENT && host_ack;
    ogpu_sync_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({st_addr, st_data}),
        .dout  (head),
        .count (fifo_count)
    );
    // handshake state register
    always_ff @(posedge clk)
        state <= reset ? ST_IDLE : next_state;
    // IDLE loads when ack is low, PRESENT waits for ack high, RELEASE waits for ack low
    always_comb begin
        next_state = state;
        next_state = load ? ST_PRESENT :
                     pop ? ST_RELEASE :
                     (state == ST_RELEASE && !host_ack) ? ST_IDLE : state;
    end
    // output words change only on the load edge so the host always sees coherent halves
    always_ff @(posedge clk)
        if (reset) begin
            store_addr      <= '0;
            store_data_high <= '0;
            store_data_low  <= '0;
            store_pending   <= 1'b0;
        end else if (load) begin
            store_addr      <= head[AW+DW-1:DW];
            store_data_high <= head[63:32];
            store_data_low  <= head[31:0];
            store_pending   <= 1'b1;
        end else if (pop) begin
            store_pending   <= 1'b0;
        end
endmodule

// File: doc/ogpu_quad_store_capture.md
Name: ogpu_quad_store_capture

Overview:
- Staging buffer between the OpenGPU quad store pipeline and the HPS-visible PIO ports.
- Accepts {address, 64-bit data} store records from the quad pipeline over a valid/ready handshake and queues them in a small FIFO.
- Presents one record at a time as stable store_addr / store_data_high / store_data_low words; these feed the upstream sides of the read-only PIO inputs.
- Pops the head record only after a 4-phase handshake with the host acknowledge PIO output, so the host always reads coherent high/low halves.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- AW, 32: store address width.
- DW, 64: store data width; fixed at 2×32 for the high/low split.

Ports:
- clk  in  1  system clock; the Qsys clock shared with the PIO slaves.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store record valid from the quad pipeline.
- st_ready  out  1  buffer can accept a record this cycle.
- st_addr  in  AW  store byte address.
- st_data  in  DW  store data.
- store_addr  out  AW  presented record address; to the address PIO in_port.
- store_data_high  out  32  presented data[63:32]; to the data_high PIO in_port.
- store_data_low  out  32  presented data[31:0]; to the data_low PIO in_port.
- store_pending  out  1  a record is presented and not yet acknowledged.
- host_ack  in  1  host acknowledge level from a PIO output register, synchronous to clk.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries, including the presented head.

Behaviour:
- Reset, sampled on the clk rising edge while reset=1:
  - FIFO pointers and count to 0.
  - store_addr, store_data_high, store_data_low to 0.
  - store_pending to 0; FSM to IDLE.
  - Reset mid-handshake discards all queued records, including the presented one.
- Enqueue:
  - st_ready = (fifo_count != DEPTH), decoded from registered count only, with no same-cycle pop look-ahead.
  - A push occurs on an edge where st_valid && st_ready.
  - st_valid without st_ready: the record is held by the producer; nothing is dropped.
- Count update: push only → +1; pop only → −1; push and pop on the same edge → unchanged.
- FSM states:
  - IDLE:
    - If count != 0 and host_ack == 0: load the head entry into the output registers, set store_pending=1, go to PRESENT.
    - Head load latency: a push into an empty FIFO at edge N gives outputs and store_pending=1 valid after edge N+1.
    - If host_ack == 1: stay in IDLE. This covers a host that left ack high across reset.
  - PRESENT:
    - Outputs are held constant.
    - On host_ack == 1: pop the head (read pointer +1, count −1), clear store_pending, go to RELEASE.
  - RELEASE:
    - store_pending stays 0; output data registers keep the last values and are not cleared.
    - On host_ack == 0: go to IDLE.
- Back-to-back throughput: with the host ack toggling immediately, one record every 3 cycles at minimum.
- Output words change only on the IDLE→PRESENT load edge. Data is therefore stable from store_pending rising until ack, and still stable afterwards until the next load.
- Pointer arithmetic is modulo DEPTH and wraps naturally. Full and empty are distinguished by count, not by pointer equality.
- A push into a full FIFO cannot occur, because st_ready=0.
- host_ack glitching high in IDLE with count==0 has no effect.

Decomposition:
- Shared package (ogpu_quad_pkg):
  - OGPU_STORE_AW = 32, OGPU_STORE_DW = 64.
  - Store record typedef {addr, data}.
  - FSM state encoding: IDLE = 2'd0, PRESENT = 2'd1, RELEASE = 2'd2.
- One sub-module: ogpu_sync_fifo.
  - Parameterised width/depth single-clock FIFO with synchronous active-high reset.
  - Provides push, pop, head data out (show-ahead) and count.
- The handshake FSM and output registers live in ogpu_quad_store_capture.

Test Plan:
- Reset with ack=0, then push addr=0x1000, data=0xDEADBEEF_CAFEF00D at edge N:
  - store_pending=1 after edge N+1, store_data_high=0xDEADBEEF, store_data_low=0xCAFEF00D, store_addr=0x1000, fifo_count=1.
  - Ack 1 then 0: pending drops on the ack-high edge, fifo_count=0, outputs retain their values.
- Push 8 records with no ack:
  - st_ready=0 and fifo_count=8 after the 8th push.
  - A 9th st_valid is held by the producer.
  - After one ack cycle, st_ready=1 and the 9th record is accepted.
- Simultaneous push and pop (ack rises in PRESENT while st_valid=1, count=3):
  - fifo_count stays 3; the next presented record is FIFO order entry 2.
- Reset asserted in PRESENT with 5 entries queued:
  - All outputs 0, fifo_count=0, st_ready=1 one edge later.
- host_ack held high through reset release with 1 entry pushed:
  - No presentation (pending=0) until ack goes low; then pending=1 on the following edge.
- Wrap-around: 20 push/ack sequences with incrementing data:
  - Every presented record matches a scoreboard in order, with no duplication or skip across the pointer wrap.
